// File: rtl/mem_ctrl_mc.sv
`default_nettype none
// ==========================================================================
// mem_ctrl_mc : CPU data-side controller, Wishbone + NUM_MEM local RAM channels
// Optional Wishbone timeout: define MEM_CTRL_TIMEOUT_EN.          Rev 1.0
// ==========================================================================
module mem_ctrl_mc #(
  parameter int                    NUM_MEM    = 2,
  parameter logic [NUM_MEM*32-1:0] MEM_BASE   = {32'h0000_4000, 32'h0000_2000},
  parameter logic [NUM_MEM*32-1:0] MEM_END    = {32'h0000_6000, 32'h0000_4000},
  parameter int                    WB_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  hold_cpu,
  output logic                  err_o,
  output logic                  wshbn_rd,
  output logic                  wshbn_wr,
  output logic [29:0]           wshbn_addr_o,
  output logic [31:0]           wshbn_data_o,
  input  logic [31:0]           wshbn_data_i,
  input  logic                  wshbn_busy,
  input  logic                  wshbn_data_av,
  output logic [NUM_MEM-1:0]    mem_rd,
  output logic [NUM_MEM-1:0]    mem_wr,
  output logic [29:0]           mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic [NUM_MEM*32-1:0] mem_data_i,
  input  logic [NUM_MEM-1:0]    mem_busy
);

  localparam int CW = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_REQ  = 3'd1,
    S_WB_WAIT = 3'd2,
    S_MEM     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [29:0]   maddr_q, maddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_q, data_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic [CW-1:0] chan_q, chan_d;

  logic          req_valid;
  logic          dec_wb;
  logic          dec_hit;
  logic [CW-1:0] dec_chan;
  logic [31:0]   dec_base;
  logic          sel_busy;
  logic [31:0]   sel_rdata;
  logic          wb_done;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + TW'(1);
`else
  logic unused_timeout;
  assign unused_timeout = ^WB_TIMEOUT;
`endif

  assign req_valid = rd ^ wr;
  assign wb_done   = is_wr_q ? !wshbn_busy : wshbn_data_av;

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    dec_wb   = addr_i < MEM_BASE[31:0];
    dec_hit  = 1'b0;
    dec_chan = '0;
    dec_base = MEM_BASE[31:0];
    for (int k = NUM_MEM - 1; k >= 0; k--) begin
      if (addr_i >= MEM_BASE[k*32 +: 32] && addr_i < MEM_END[k*32 +: 32]) begin
        dec_hit  = 1'b1;
        dec_chan = CW'(k);
        dec_base = MEM_BASE[k*32 +: 32];
      end
    end
  end

  always_comb begin
    sel_busy  = 1'b0;
    sel_rdata = '0;
    mem_rd    = '0;
    mem_wr    = '0;
    for (int k = 0; k < NUM_MEM; k++) begin
      if (chan_q == CW'(k)) begin
        sel_busy  = mem_busy[k];
        sel_rdata = mem_data_i[k*32 +: 32];
        mem_rd[k] = (state_q == S_MEM) && !is_wr_q;
        mem_wr[k] = (state_q == S_MEM) && is_wr_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    chan_d   = chan_q;
    data_d   = data_q;
    err_d    = err_q;
    hold_cpu = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          hold_cpu = 1'b1;
          waddr_d  = addr_i[31:2];
          // Word offset of (addr - base), borrow from the byte bits folded in.
          maddr_d  = addr_i[31:2] - dec_base[31:2]
                   - {29'd0, (addr_i[1:0] < dec_base[1:0])};
          wdata_d  = data_i;
          is_wr_d  = wr;
          chan_d   = dec_chan;
          if (dec_wb) begin
            state_d = S_WB_REQ;
          end else if (dec_hit) begin
            state_d = S_MEM;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_WB_REQ: begin
        hold_cpu = 1'b1;
        state_d  = S_WB_WAIT;
`ifdef MEM_CTRL_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      S_WB_WAIT: begin
        hold_cpu = 1'b1;
        if (wb_done) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!is_wr_q) data_d = wshbn_data_i;
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        else if (cnt_inc == TW'(WB_TIMEOUT)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!is_wr_q) data_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      S_MEM: begin
        hold_cpu = 1'b1;
        if (!sel_busy) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!is_wr_q) data_d = sel_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wshbn_rd     = (state_q == S_WB_REQ) && !is_wr_q;
  assign wshbn_wr     = (state_q == S_WB_REQ) && is_wr_q;
  assign wshbn_addr_o = waddr_q;
  assign wshbn_data_o = wdata_q;
  assign mem_addr_o   = maddr_q;
  assign mem_data_o   = wdata_q;
  assign data_o       = data_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire
